// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths and write-port arbiter state encoding
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rf_wq_fifo.sv
// rtl/rf_wq_fifo.sv - auxiliary write queue with per-entry valid bits and pending-write address compare
module rf_wq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0]     push_din,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  input  logic [REG_ADDR_W-1:0] qry_rs,
  input  logic [REG_ADDR_W-1:0] qry_rt,
  output logic                  ready,
  output logic                  head_valid,
  output logic                  head_live,
  output logic                  last,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0]     head_din,
  output logic                  hit_rs,
  output logic                  hit_rt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [REG_ADDR_W-1:0] rd_mem  [DEPTH];
  logic [DATA_W-1:0]     din_mem [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [PW-1:0]         wptr, rptr;
  logic [PW:0]           count, count_next;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + ONE_CNT;
    else if (!push && pop)
      count_next = count - ONE_CNT;
  end

  // A squashed slot stays occupied until it reaches the head, so ordering and occupancy are untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
      ready <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && vld[i] && rd_mem[i] == squash_rd)
          vld[i] <= 1'b0;
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + PW'(1);
      end
      if (push) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + PW'(1);
      end
      count <= count_next;
      ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[wptr]  <= push_rd;
      din_mem[wptr] <= push_din;
    end
  end

  assign head_valid = (count != '0);
  assign head_live  = vld[rptr];
  assign last       = (count == ONE_CNT);
  assign head_rd    = rd_mem[rptr];
  assign head_din   = din_mem[rptr];

  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && rd_mem[i] == qry_rs && qry_rs != '0) hit_rs = 1'b1;
      if (vld[i] && rd_mem[i] == qry_rt && qry_rt != '0) hit_rt = 1'b1;
    end
  end
endmodule

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - register-file write-port sharing between writeback and an auxiliary unit
// Optional WAW squash of queued entries: RF_WPORT_WAW_SQUASH_EN.
module rf_wport_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_din,
  input  logic                  aux_valid,
  input  logic [REG_ADDR_W-1:0] aux_rd,
  input  logic [DATA_W-1:0]     aux_din,
  output logic                  aux_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_din,
  output logic                  stall_req,
  input  logic [REG_ADDR_W-1:0] qry_rs,
  input  logic [REG_ADDR_W-1:0] qry_rt,
  output logic                  hit_rs,
  output logic                  hit_rt
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_TRIP = CW'(STARVE_LIMIT - 1);

  logic                  pipe_busy, push, pop, squash, blocked;
  logic                  head_valid, head_live, last;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_din;
  logic [CW-1:0]         starve_cnt;
  arb_state_t            state;

  assign pipe_busy = wb_we && (wb_rd != '0);
  assign push      = aux_valid && aux_ready && (aux_rd != '0);
  // A squashed head frees its slot without touching the register file, so the pipeline cannot block it.
  assign pop       = head_valid && (!head_live || !pipe_busy);
  assign blocked   = head_valid && head_live && pipe_busy;

`ifdef RF_WPORT_WAW_SQUASH_EN
  assign squash = pipe_busy;
`else
  assign squash = 1'b0;
`endif

  rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_rd    (aux_rd),
    .push_din   (aux_din),
    .pop        (pop),
    .squash     (squash),
    .squash_rd  (wb_rd),
    .qry_rs     (qry_rs),
    .qry_rt     (qry_rt),
    .ready      (aux_ready),
    .head_valid (head_valid),
    .head_live  (head_live),
    .last       (last),
    .head_rd    (head_rd),
    .head_din   (head_din),
    .hit_rs     (hit_rs),
    .hit_rt     (hit_rt)
  );

  always_comb begin
    rf_we  = 1'b0;
    rf_rd  = '0;
    rf_din = '0;
    if (!reset) begin
      if (pipe_busy) begin
        rf_we  = 1'b1;
        rf_rd  = wb_rd;
        rf_din = wb_din;
      end else if (head_valid && head_live) begin
        rf_we  = 1'b1;
        rf_rd  = head_rd;
        rf_din = head_din;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          starve_cnt <= '0;
          if (push) state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (pop) begin
            starve_cnt <= '0;
            if (last && !push) state <= ARB_IDLE;
          end else if (blocked) begin
            starve_cnt <= starve_cnt + CW'(1);
            if (starve_cnt + CW'(1) >= CNT_TRIP) begin
              state     <= ARB_FORCE;
              stall_req <= 1'b1;
            end
          end
        end
        ARB_FORCE: begin
          if (pop) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            state      <= (last && !push) ? ARB_IDLE : ARB_WAIT;
          end
        end
        default: begin
          state      <= ARB_IDLE;
          starve_cnt <= '0;
          stall_req  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - scoreboard bench for rf_wport_arbiter against a queue-based reference model
module tb_rf_wport_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_din;
  logic        aux_valid;
  logic [4:0]  aux_rd;
  logic [31:0] aux_din;
  logic        aux_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;
  logic        stall_req;
  logic [4:0]  qry_rs, qry_rt;
  logic        hit_rs, hit_rt;

  always #5 clock = ~clock;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock     (clock),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_din    (wb_din),
    .aux_valid (aux_valid),
    .aux_rd    (aux_rd),
    .aux_din   (aux_din),
    .aux_ready (aux_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_din    (rf_din),
    .stall_req (stall_req),
    .qry_rs    (qry_rs),
    .qry_rt    (qry_rt),
    .hit_rs    (hit_rs),
    .hit_rt    (hit_rt)
  );

  typedef struct { logic [4:0] rd; logic [31:0] din; bit live; } ent_t;
  typedef struct { bit we; logic [4:0] rd; logic [31:0] din; bit ready; bit stall; bit hrs; bit hrt; } st_t;
  typedef struct { logic [4:0] rd; logic [31:0] din; } wr_t;

  ent_t        mq[$];
  st_t         st_q[$];
  wr_t         wr_q[$];
  int          blocked;
  logic [31:0] model_rf  [32];
  logic [31:0] shadow_rf [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, from the model state before the coming edge.
  task automatic expect_cycle();
    st_t s;
    bit  pb;
    pb = wb_we && (wb_rd != 5'd0);
    s.we = 0; s.rd = '0; s.din = '0; s.ready = 1; s.stall = 0; s.hrs = 0; s.hrt = 0;
    if (!reset) begin
      s.ready = (mq.size() < DEPTH);
      s.stall = (mq.size() > 0) && (blocked >= STARVE_LIMIT - 1);
      foreach (mq[i]) begin
        if (mq[i].live && mq[i].rd == qry_rs && qry_rs != 5'd0) s.hrs = 1;
        if (mq[i].live && mq[i].rd == qry_rt && qry_rt != 5'd0) s.hrt = 1;
      end
      if (pb) begin
        s.we = 1; s.rd = wb_rd; s.din = wb_din;
      end else if (mq.size() > 0 && mq[0].live) begin
        s.we = 1; s.rd = mq[0].rd; s.din = mq[0].din;
      end
    end
    st_q.push_back(s);
    if (s.we) begin
      wr_t w;
      w.rd = s.rd; w.din = s.din;
      wr_q.push_back(w);
      model_rf[s.rd] = s.din;
    end
  endtask

  // Model state change at the edge, using the inputs that were held during the cycle.
  task automatic update_model();
    bit pb, rdy, was_blocked, popped;
    ent_t e;
    if (reset) begin
      mq.delete();
      blocked = 0;
      return;
    end
    pb          = wb_we && (wb_rd != 5'd0);
    rdy         = (mq.size() < DEPTH);
    was_blocked = (mq.size() > 0) && mq[0].live && pb;
    popped      = 0;
    if (mq.size() > 0 && (!mq[0].live || !pb)) begin
      void'(mq.pop_front());
      popped = 1;
    end
`ifdef RF_WPORT_WAW_SQUASH_EN
    if (pb) foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 0;
`endif
    if (popped) blocked = 0;
    else if (was_blocked) blocked++;
    if (aux_valid && rdy && aux_rd != 5'd0) begin
      e.rd = aux_rd; e.din = aux_din; e.live = 1;
      mq.push_back(e);
    end
    if (mq.size() == 0) blocked = 0;
  endtask

  task automatic step();
    expect_cycle();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic drv(bit we, logic [4:0] wrd, logic [31:0] wdin, bit av, logic [4:0] ard, logic [31:0] adin);
    wb_we = we; wb_rd = wrd; wb_din = wdin;
    aux_valid = av; aux_rd = ard; aux_din = adin;
  endtask

  always @(negedge clock) begin : monitor
    st_t s;
    wr_t w;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      check("rf_we",     32'(rf_we),     32'(s.we));
      check("aux_ready", 32'(aux_ready), 32'(s.ready));
      check("stall_req", 32'(stall_req), 32'(s.stall));
      check("hit_rs",    32'(hit_rs),    32'(s.hrs));
      check("hit_rt",    32'(hit_rt),    32'(s.hrt));
    end
    if (rf_we === 1'b1) begin
      shadow_rf[rf_rd] = rf_din;
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got rd=%0d din=0x%0h expected no write at t=%0t", rf_rd, rf_din, $time);
      end else begin
        w = wr_q.pop_front();
        check("rf_rd",  32'(rf_rd), 32'(w.rd));
        check("rf_din", rf_din,     w.din);
      end
    end
  end

  initial begin
    int mode;
    logic [31:0] waw_exp;
    for (int i = 0; i < 32; i++) begin
      model_rf[i]  = '0;
      shadow_rf[i] = '0;
    end
    blocked = 0;
    reset = 1'b1;
    drv(0, 0, 0, 1, 5'd5, 32'h1);
    qry_rs = 5'd5; qry_rt = 5'd0;
    @(posedge clock);
    #1;

    // Reset held with an offer present
    repeat (4) step();
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step();

    // Single push into an idle pipeline
    drv(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    step();
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Fill while writeback is busy, then release
    for (int k = 0; k < 6; k++) begin
      drv(1, 5'd1, 32'h100 + k, 1, 5'(10 + k), 32'hA000 + k);
      qry_rs = 5'(10 + k); qry_rt = 5'd13;
      step();
    end
    drv(0, 0, 0, 1, 5'd20, 32'hA0A0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Starvation with one queued entry
    drv(1, 5'd2, 32'h22, 1, 5'd3, 32'h3333);
    step();
    for (int k = 0; k < 10; k++) begin
      drv(1, 5'd2, 32'h200 + k, 0, 0, 0);
      step();
    end
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Handshake with rd=0 enqueues nothing
    drv(0, 0, 0, 1, 5'd0, 32'hBAD0BAD0);
    qry_rs = 5'd0; qry_rt = 5'd0;
    step();
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // Write-after-write on r7
    drv(1, 5'd9, 32'h9, 1, 5'd7, 32'hAAAA0007);
    step();
    drv(1, 5'd7, 32'hBBBB0007, 0, 0, 0);
    qry_rs = 5'd7;
    step();
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    @(negedge clock);
    #1;
`ifdef RF_WPORT_WAW_SQUASH_EN
    waw_exp = 32'hBBBB0007;
`else
    waw_exp = 32'hAAAA0007;
`endif
    check("waw_r7_final", shadow_rf[7], waw_exp);
    @(posedge clock);
    #1;

    // Randomized traffic with bursty writeback and rare mid-operation resets
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) mode = $urandom_range(0, 2);
      reset     = ($urandom_range(0, 499) == 0);
      wb_we     = (mode == 2) ? 1'b1 : ($urandom_range(0, 9) < (mode == 0 ? 2 : 6));
      wb_rd     = 5'($urandom_range(0, 7));
      wb_din    = $urandom;
      aux_valid = $urandom_range(0, 1) == 1;
      aux_rd    = 5'($urandom_range(0, 7));
      aux_din   = $urandom;
      qry_rs    = 5'($urandom_range(0, 7));
      qry_rt    = 5'($urandom_range(0, 7));
      step();
    end

    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    repeat (12) step();
    @(negedge clock);
    #1;
    check("writes_left", 32'(wr_q.size()), 32'd0);
    check("model_empty", 32'(mq.size()), 32'd0);
    for (int r = 1; r < 32; r++) check("regfile", shadow_rf[r], model_rf[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
